// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple adder with dataflow, behavioural and case cells.
// Define FA_XCHECK_EN to register a flag when the three cell styles disagree.
module fa_df (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module fa_bh (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   always_comb begin
      if (a == b) begin
         s  = ci;
         co = a;
      end else begin
         s  = ~ci;
         co = ci;
      end
   end
endmodule

module fa_cs (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   always_comb begin
      {co, s} = 2'b00;
      case ({ci, a, b})
         3'b000:  {co, s} = 2'b00;
         3'b001:  {co, s} = 2'b01;
         3'b010:  {co, s} = 2'b01;
         3'b011:  {co, s} = 2'b10;
         3'b100:  {co, s} = 2'b01;
         3'b101:  {co, s} = 2'b10;
         3'b110:  {co, s} = 2'b10;
         3'b111:  {co, s} = 2'b11;
         default: {co, s} = 2'b00;
      endcase
   end
endmodule

module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic [1:0]       sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             mismatch
);
   logic [WIDTH-1:0] s_df, s_bh, s_cs;
   logic [WIDTH:0]   c_df, c_bh, c_cs;
   logic [WIDTH:0]   r_df, r_bh, r_cs, r_sel;

   assign c_df[0] = ci;
   assign c_bh[0] = ci;
   assign c_cs[0] = ci;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_df u_df (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c_df[i]),
         .s  (s_df[i]),
         .co (c_df[i+1])
      );
      fa_bh u_bh (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c_bh[i]),
         .s  (s_bh[i]),
         .co (c_bh[i+1])
      );
      fa_cs u_cs (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c_cs[i]),
         .s  (s_cs[i]),
         .co (c_cs[i+1])
      );
   end

   assign r_df = {c_df[WIDTH], s_df};
   assign r_bh = {c_bh[WIDTH], s_bh};
   assign r_cs = {c_cs[WIDTH], s_cs};

   always_comb begin
      r_sel = r_df;
      case (sel)
         2'd1:    r_sel = r_bh;
         2'd2:    r_sel = r_cs;
         default: r_sel = r_df;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         s         <= '0;
         co        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            {co, s} <= r_sel;
         end
      end
   end

`ifdef FA_XCHECK_EN
   logic xdiff;

   assign xdiff = (r_df != r_bh) || (r_df != r_cs);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= 1'b0;
      end else if (in_valid) begin
         mismatch <= xdiff;
      end
   end
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH 1/4/8 instances against an arithmetic model.
// Literal spot checks pin the model; a negedge process compares every cycle.
module tb_full_adder;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   bit   chk_en;

   logic       v1, a1, b1, ci1;
   logic [1:0] sel1;
   logic       ov1, s1, co1, mm1;

   logic       v4, ci4;
   logic [3:0] a4, b4, s4;
   logic [1:0] sel4;
   logic       ov4, co4, mm4;

   logic       v8, ci8;
   logic [7:0] a8, b8, s8;
   logic [1:0] sel8;
   logic       ov8, co8, mm8;

   logic [1:0] m1;
   logic [4:0] m4;
   logic [8:0] m8;
   logic       e1, e4, e8;

   full_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1),
      .a(a1), .b(b1), .ci(ci1), .sel(sel1),
      .out_valid(ov1), .s(s1), .co(co1), .mismatch(mm1)
   );
   full_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4),
      .a(a4), .b(b4), .ci(ci4), .sel(sel4),
      .out_valid(ov4), .s(s4), .co(co4), .mismatch(mm4)
   );
   full_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8),
      .a(a8), .b(b8), .ci(ci8), .sel(sel8),
      .out_valid(ov8), .s(s8), .co(co8), .mismatch(mm8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: registered {co,s} is simply a+b+ci, held while not valid
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= '0; m4 <= '0; m8 <= '0;
         e1 <= 1'b0; e4 <= 1'b0; e8 <= 1'b0;
      end else begin
         e1 <= v1; e4 <= v4; e8 <= v8;
         if (v1) m1 <= 2'(a1) + 2'(b1) + 2'(ci1);
         if (v4) m4 <= 5'(a4) + 5'(b4) + 5'(ci4);
         if (v8) m8 <= 9'(a8) + 9'(b8) + 9'(ci8);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_w1_sum", 32'({co1, s1}), 32'(m1));
         check("cmp_w1_ov", 32'(ov1), 32'(e1));
         check("cmp_w1_mm", 32'(mm1), 32'd0);
         check("cmp_w4_sum", 32'({co4, s4}), 32'(m4));
         check("cmp_w4_ov", 32'(ov4), 32'(e4));
         check("cmp_w4_mm", 32'(mm4), 32'd0);
         check("cmp_w8_sum", 32'({co8, s8}), 32'(m8));
         check("cmp_w8_ov", 32'(ov8), 32'(e8));
         check("cmp_w8_mm", 32'(mm8), 32'd0);
      end
   end

   initial begin
      int cnt;
      logic [2:0] vec;
      n_chk = 0; n_fail = 0; chk_en = 1'b0;
      rst_n = 1'b0;
      v1 = 0; a1 = 0; b1 = 0; ci1 = 0; sel1 = 0;
      v4 = 0; a4 = 0; b4 = 0; ci4 = 0; sel4 = 0;
      v8 = 0; a8 = 0; b8 = 0; ci8 = 0; sel8 = 0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      check("rst_s", 32'(s1), 32'd0);
      check("rst_co", 32'(co1), 32'd0);
      check("rst_ov", 32'(ov1), 32'd0);
      check("rst_mm", 32'(mm1), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int sl = 0; sl < 3; sl++) begin
         for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            vec = 3'(v);
            v1 = 1'b1; {ci1, a1, b1} = vec; sel1 = 2'(sl);
            @(posedge clk); #1;
            cnt = int'(vec[0]) + int'(vec[1]) + int'(vec[2]);
            check("w1_exh_s", 32'(s1), 32'(cnt % 2));
            check("w1_exh_co", 32'(co1), 32'(cnt / 2));
            check("w1_exh_ov", 32'(ov1), 32'd1);
            if (vec == 3'b011) check("w1_011", 32'({s1, co1}), 32'b01);
            if (vec == 3'b100) check("w1_100", 32'({s1, co1}), 32'b10);
            if (vec == 3'b111) check("w1_111", 32'({s1, co1}), 32'b11);
         end
      end

      @(negedge clk);
      {ci1, a1, b1} = 3'b110; sel1 = 2'd3;
      @(posedge clk); #1;
      check("sel3_s", 32'(s1), 32'd0);
      check("sel3_co", 32'(co1), 32'd1);

      @(negedge clk);
      v1 = 1'b0;
      v4 = 1'b1; a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; sel4 = 2'd0;
      @(posedge clk); #1;
      check("w4_f1_s", 32'(s4), 32'h0);
      check("w4_f1_co", 32'(co4), 32'd1);
      @(negedge clk);
      a4 = 4'h5; b4 = 4'hA; ci4 = 1'b1; sel4 = 2'd2;
      @(posedge clk); #1;
      check("w4_5a_s", 32'(s4), 32'h0);
      check("w4_5a_co", 32'(co4), 32'd1);

      @(negedge clk);
      v4 = 1'b0;
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0; sel1 = 2'd1;
      @(negedge clk);
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("hold_s", 32'(s1), 32'd0);
         check("hold_co", 32'(co1), 32'd1);
         check("hold_ov", 32'(ov1), 32'd0);
      end

      @(negedge clk);
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; sel1 = 2'd0;
      @(posedge clk); #1;
      check("pre_rst_s", 32'(s1), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_s", 32'(s1), 32'd0);
      check("async_rst_co", 32'(co1), 32'd0);
      check("async_rst_ov", 32'(ov1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; v1 = 1'b0;

      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         v1 = ($urandom_range(0, 7) != 0);
         v4 = ($urandom_range(0, 7) != 0);
         v8 = ($urandom_range(0, 7) != 0);
         {ci1, a1, b1} = 3'($urandom);
         {ci4, a4, b4} = 9'($urandom);
         {ci8, a8, b8} = 17'($urandom);
         sel1 = 2'($urandom); sel4 = 2'($urandom); sel8 = 2'($urandom);
      end
      @(negedge clk);
      v1 = 0; v4 = 0; v8 = 0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
